// File: rtl/audio_sample_sequencer.sv
// Sample-rate scheduler: divides clk to a sample tick and runs one
// ADC capture -> filter -> DAC write sequence per tick, with overrun and timeout flags.
module audio_sample_sequencer #(
    parameter int DIV_MAX = 2000,
    parameter int CNT_W   = 11,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic              o_sample_tick,
    output logic              o_adc_req,
    input  logic              i_adc_ack,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_flt_start,
    output logic [DATA_W-1:0] o_flt_din,
    input  logic              i_flt_done,
    input  logic [DATA_W-1:0] i_flt_dout,
    output logic              o_dac_we,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout_err,
    input  logic              i_err_clr
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADC_WAIT  = 3'd1;
    localparam logic [2:0] S_FLT_START = 3'd2;
    localparam logic [2:0] S_FLT_WAIT  = 3'd3;
    localparam logic [2:0] S_DAC_WR    = 3'd4;

    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick;
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              w_wait_expired;
    logic              w_adc_take;
    logic              w_flt_take;
    logic              w_to_set;
    logic              w_ovr_set;
    logic [DATA_W-1:0] r_flt_din;
    logic [DATA_W-1:0] r_dac_data;
    logic              r_overrun;
    logic              r_timeout_err;

    // Tick is registered, so it lands one cycle after the counter's last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_en && (r_cnt == CNT_LAST);
            if (!i_en || (r_cnt == CNT_LAST))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_adc_take     = 1'b0;
        w_flt_take     = 1'b0;
        w_to_set       = 1'b0;
        w_wait_expired = (r_wait == WAIT_LAST);
        case (r_state)
            S_IDLE: begin
                if (r_tick)
                    w_state_nxt = S_ADC_WAIT;
            end
            S_ADC_WAIT: begin
                if (i_adc_ack) begin
                    w_adc_take  = 1'b1;
                    w_state_nxt = S_FLT_START;
                end else if (w_wait_expired) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLT_START: w_state_nxt = S_FLT_WAIT;
            S_FLT_WAIT: begin
                if (i_flt_done) begin
                    w_flt_take  = 1'b1;
                    w_state_nxt = S_DAC_WR;
                end else if (w_wait_expired) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DAC_WR: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // A tick while a sequence is in flight is dropped and only flagged.
        w_ovr_set = r_tick && (r_state != S_IDLE);
    end

    // The wait counter only advances while parked in a wait state, so it is zero on entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_flt_din  <= '0;
            r_dac_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (((r_state == S_ADC_WAIT) || (r_state == S_FLT_WAIT)) && (w_state_nxt == r_state))
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (w_adc_take)
                r_flt_din <= i_adc_data;
            if (w_flt_take)
                r_dac_data <= i_flt_dout;
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (i_err_clr)
                r_overrun <= 1'b0;
            if (w_to_set)
                r_timeout_err <= 1'b1;
            else if (i_err_clr)
                r_timeout_err <= 1'b0;
        end
    end

    assign o_sample_tick = r_tick;
    assign o_adc_req     = (r_state == S_ADC_WAIT);
    assign o_flt_start   = (r_state == S_FLT_START);
    assign o_dac_we      = (r_state == S_DAC_WR);
    assign o_busy        = (r_state != S_IDLE);
    assign o_flt_din     = r_flt_din;
    assign o_dac_data    = r_dac_data;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer: table vectors, randomized
// transactions against a latency-arithmetic model, and hand-written corner cases.
module tb_audio_sample_sequencer;

    localparam int DIV = 8;
    localparam int TO  = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_adc_ack = 1'b0;
    logic [15:0] i_adc_data = '0;
    logic        i_flt_done = 1'b0;
    logic [15:0] i_flt_dout = '0;
    logic        i_err_clr = 1'b0;
    logic        o_sample_tick, o_adc_req, o_flt_start, o_dac_we;
    logic        o_busy, o_overrun, o_timeout_err;
    logic [15:0] o_flt_din, o_dac_data;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int lastTick = 0;
    bit havePrev = 1'b0;

    typedef struct {
        int          ackDly;
        int          doneDly;
        logic [15:0] adcVal;
        logic [15:0] fltVal;
        int          expStartOfs;
        int          expWeOfs;
    } vec_t;

    vec_t vecs[6];

    audio_sample_sequencer #(
        .DIV_MAX(DIV), .CNT_W(3), .DATA_W(16), .TIMEOUT(TO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .o_sample_tick(o_sample_tick),
        .o_adc_req(o_adc_req), .i_adc_ack(i_adc_ack), .i_adc_data(i_adc_data),
        .o_flt_start(o_flt_start), .o_flt_din(o_flt_din),
        .i_flt_done(i_flt_done), .i_flt_dout(i_flt_dout),
        .o_dac_we(o_dac_we), .o_dac_data(o_dac_data),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_timeout_err(o_timeout_err),
        .i_err_clr(i_err_clr)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        i_en = 1'b0;
        i_adc_ack = 1'b0;
        i_flt_done = 1'b0;
        i_err_clr = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        havePrev = 1'b0;
    endtask

    task automatic nextTick();
        int n = 0;
        while (!o_sample_tick && n < 3 * DIV) begin
            step();
            n++;
        end
        checkOutput("tick_seen", o_sample_tick, 1);
        if (havePrev)
            checkOutput("tick_period", cyc - lastTick, DIV);
        havePrev = 1'b1;
        lastTick = cyc;
    endtask

    // Called in the tick cycle; latencies are measured relative to it.
    task automatic applyStimulus(input vec_t v);
        int t0;
        int n;
        t0 = cyc;
        step();
        checkOutput("adc_req_rise", o_adc_req, 1);
        repeat (v.ackDly) step();
        i_adc_ack = 1'b1;
        i_adc_data = v.adcVal;
        step();
        i_adc_ack = 1'b0;
        i_adc_data = 16'($urandom);
        n = 0;
        while (!o_flt_start && n < 20) begin
            step();
            n++;
        end
        checkOutput("flt_start_latency", cyc - t0, v.expStartOfs);
        checkOutput("flt_din", o_flt_din, v.adcVal);
        checkOutput("adc_req_drop", o_adc_req, 0);
        step();
        checkOutput("flt_start_width", o_flt_start, 0);
        repeat (v.doneDly) step();
        i_flt_done = 1'b1;
        i_flt_dout = v.fltVal;
        step();
        i_flt_done = 1'b0;
        i_flt_dout = 16'($urandom);
        n = 0;
        while (!o_dac_we && n < 20) begin
            step();
            n++;
        end
        checkOutput("dac_we_latency", cyc - t0, v.expWeOfs);
        checkOutput("dac_data", o_dac_data, v.fltVal);
        step();
        checkOutput("dac_we_width", o_dac_we, 0);
        checkOutput("idle_after_seq", o_busy, 0);
        checkOutput("dac_data_hold", o_dac_data, v.fltVal);
        checkOutput("no_overrun", o_overrun, 0);
    endtask

    initial begin
        int   n;
        int   t0;
        int   weCount;
        int   firstOvr;
        logic bad;
        vec_t r;

        // Expected offsets from the tick: flt_start = 2+ack delay, dac_we = 4+ack+done delays.
        vecs[0] = '{0, 2, 16'h1234, 16'hBEEF, 2, 6};
        vecs[1] = '{0, 0, 16'hA5A5, 16'h0001, 2, 4};
        vecs[2] = '{1, 1, 16'hFFFF, 16'h8000, 3, 6};
        vecs[3] = '{3, 0, 16'h0000, 16'hFFFF, 5, 7};
        vecs[4] = '{0, 3, 16'h7FFF, 16'h1357, 2, 7};
        vecs[5] = '{2, 1, 16'hC0DE, 16'hF00D, 4, 7};

        doReset();
        checkOutput("reset_outputs", {o_sample_tick, o_adc_req, o_flt_start, o_dac_we,
                                      o_busy, o_overrun, o_timeout_err}, 0);
        checkOutput("reset_data", {o_flt_din, o_dac_data}, 0);

        // Back-to-back sequences that each fit inside one tick period.
        i_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nextTick();
            applyStimulus(vecs[i]);
        end
        for (int i = 0; i < 30; i++) begin
            r.ackDly      = int'($urandom_range(3));
            r.doneDly     = int'($urandom_range(3 - r.ackDly));
            r.adcVal      = 16'($urandom);
            r.fltVal      = 16'($urandom);
            r.expStartOfs = 2 + r.ackDly;
            r.expWeOfs    = 4 + r.ackDly + r.doneDly;
            nextTick();
            applyStimulus(r);
        end

        // Filter stalls past the next tick: overrun, single dac_we, then clear.
        doReset();
        i_en = 1'b1;
        nextTick();
        t0 = cyc;
        step();
        i_adc_ack = 1'b1;
        i_adc_data = 16'h0F0F;
        step();
        i_adc_ack = 1'b0;
        step();
        weCount = 0;
        firstOvr = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            weCount += int'(o_dac_we);
            if (o_overrun && firstOvr < 0)
                firstOvr = cyc - t0;
        end
        i_flt_done = 1'b1;
        i_flt_dout = 16'h7E57;
        step();
        i_flt_done = 1'b0;
        weCount += int'(o_dac_we);
        checkOutput("ovr_dac_data", o_dac_data, 16'h7E57);
        for (int k = 0; k < 4; k++) begin
            step();
            weCount += int'(o_dac_we);
        end
        checkOutput("ovr_first_cycle", firstOvr, 9);
        checkOutput("ovr_single_we", weCount, 1);
        checkOutput("ovr_sticky", o_overrun, 1);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        checkOutput("ovr_cleared", o_overrun, 0);

        // ADC never acks; err_clr held throughout, so set events must win.
        doReset();
        i_en = 1'b1;
        nextTick();
        step();
        i_err_clr = 1'b1;
        n = 0;
        bad = 1'b0;
        while (o_adc_req && n < 40) begin
            n++;
            step();
            bad |= o_dac_we;
        end
        checkOutput("to_req_cycles", n, TO);
        checkOutput("to_err_set", o_timeout_err, 1);
        checkOutput("to_ovr_set_wins", o_overrun, 1);
        checkOutput("to_idle", o_busy, 0);
        checkOutput("to_no_we", bad, 0);
        step();
        i_err_clr = 1'b0;
        checkOutput("to_err_cleared", {o_timeout_err, o_overrun}, 0);

        // Ack on the expiry cycle beats the timeout.
        doReset();
        i_en = 1'b1;
        nextTick();
        step();
        repeat (TO - 1) step();
        i_adc_ack = 1'b1;
        i_adc_data = 16'h4242;
        step();
        i_adc_ack = 1'b0;
        checkOutput("late_ack_start", o_flt_start, 1);
        checkOutput("late_ack_no_err", o_timeout_err, 0);
        checkOutput("late_ack_din", o_flt_din, 16'h4242);

        // Dropping en mid-sequence lets the sequence finish.
        doReset();
        i_en = 1'b1;
        nextTick();
        step();
        i_en = 1'b0;
        i_adc_ack = 1'b1;
        i_adc_data = 16'h1111;
        step();
        i_adc_ack = 1'b0;
        step();
        i_flt_done = 1'b1;
        i_flt_dout = 16'h2222;
        step();
        i_flt_done = 1'b0;
        checkOutput("en_drop_we", o_dac_we, 1);
        checkOutput("en_drop_data", o_dac_data, 16'h2222);

        // Reset during FLT_WAIT: outputs clear at once, no write follows.
        doReset();
        i_en = 1'b1;
        nextTick();
        step();
        i_adc_ack = 1'b1;
        i_adc_data = 16'h5A5A;
        step();
        i_adc_ack = 1'b0;
        step();
        step();
        checkOutput("pre_rst_busy", o_busy, 1);
        i_rst = 1'b1;
        #1;
        checkOutput("rst_async_flags", {o_sample_tick, o_adc_req, o_flt_start, o_dac_we,
                                        o_busy, o_overrun, o_timeout_err}, 0);
        checkOutput("rst_async_data", {o_flt_din, o_dac_data}, 0);
        i_flt_done = 1'b1;
        i_flt_dout = 16'h9999;
        step();
        step();
        i_flt_done = 1'b0;
        i_rst = 1'b0;
        n = 0;
        bad = 1'b0;
        while (!o_sample_tick && n < 30) begin
            step();
            n++;
            bad |= o_dac_we;
        end
        checkOutput("rst_first_tick", n, DIV);
        checkOutput("rst_no_we", bad, 0);

        // en=0: handshake inputs toggling must not start anything.
        doReset();
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            i_adc_ack = 1'($urandom);
            i_flt_done = 1'($urandom);
            i_adc_data = 16'($urandom);
            i_flt_dout = 16'($urandom);
            step();
            bad |= o_sample_tick | o_adc_req | o_flt_start | o_dac_we | o_busy;
        end
        i_adc_ack = 1'b0;
        i_flt_done = 1'b0;
        checkOutput("en0_quiet", bad, 0);
        checkOutput("en0_no_latch", {o_flt_din, o_dac_data}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
